// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - four-digit multiplexed seven-segment scanner
//
// Purpose: double-buffers four BCD digits and scans them onto one shared
// segment bus with one-hot digit enables, inter-digit blanking, optional
// leading-zero suppression and a frame-start pulse.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_digits_in    four BCD digits, [3:0] = digit 0 (rightmost)
//   i_load         single-cycle strobe capturing i_digits_in into the shadow
//   i_lz_blank     1 = blank leading zeros (digit 0 always shown)
//   o_led_out      segments a..g on bits 6..0, active-high
//   o_digit_en     one-hot digit enable, bit i = digit i
//   o_frame_start  one-cycle pulse on cycle 0 of slot 0
module seven_segment_scan #(
  parameter int SCAN_DIV     = 16000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_digits_in,
  input  logic        i_load,
  input  logic        i_lz_blank,
  output logic [6:0]  o_led_out,
  output logic [3:0]  o_digit_en,
  output logic        o_frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  // r_cnt/r_idx/r_active describe the cycle currently on the outputs.
  // r_run is clear for the one edge after reset so that edge produces
  // cycle 0 of slot 0 instead of advancing past it.
  logic          r_run;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [15:0]   r_active;
  logic [6:0]    r_led;
  logic [3:0]    r_en;
  logic          r_fs;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_active_nxt;
  logic [3:0]    w_digit;
  logic          w_upper_zero;
  logic          w_suppress;
  logic [6:0]    w_seg;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = r_run && w_slot_end && (r_idx == 2'd3);

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    if (r_run) begin
      if (w_slot_end) begin
        w_cnt_nxt = '0;
        w_idx_nxt = r_idx + 2'd1;
      end else begin
        w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // A load on the frame-boundary edge bypasses the shadow so it is shown
  // in the very next frame.
  assign w_active_nxt = w_frame_end ? (i_load ? i_digits_in : r_shadow) : r_active;

  // Outputs are registered from next-state so they line up with the state
  // of the cycle they are displayed in.
  assign w_digit = 4'(w_active_nxt >> {w_idx_nxt, 2'b00});

  always_comb begin
    w_upper_zero = 1'b0;
    case (w_idx_nxt)
      2'd1:    w_upper_zero = (w_active_nxt[15:4]  == 12'd0);
      2'd2:    w_upper_zero = (w_active_nxt[15:8]  == 8'd0);
      2'd3:    w_upper_zero = (w_active_nxt[15:12] == 4'd0);
      default: w_upper_zero = 1'b0;
    endcase
  end

  assign w_suppress = i_lz_blank && w_upper_zero;

  always_comb begin
    w_seg = 7'b0000000;
    case (w_digit)
      4'd0:    w_seg = 7'b1111110;
      4'd1:    w_seg = 7'b0110000;
      4'd2:    w_seg = 7'b1101101;
      4'd3:    w_seg = 7'b1111001;
      4'd4:    w_seg = 7'b0110011;
      4'd5:    w_seg = 7'b1011011;
      4'd6:    w_seg = 7'b1011111;
      4'd7:    w_seg = 7'b1110000;
      4'd8:    w_seg = 7'b1111111;
      4'd9:    w_seg = 7'b1111011;
      default: w_seg = 7'b0000000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_shadow <= 16'd0;
      r_active <= 16'd0;
      r_led    <= 7'd0;
      r_en     <= 4'd0;
      r_fs     <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_active <= w_active_nxt;
      if (i_load) begin
        r_shadow <= i_digits_in;
      end
      r_fs <= (w_cnt_nxt == '0) && (w_idx_nxt == 2'd0);
      if (w_cnt_nxt < CNT_BLANK) begin
        r_en  <= 4'd0;
        r_led <= 7'd0;
      end else begin
        r_en  <= 4'b0001 << w_idx_nxt;
        r_led <= w_suppress ? 7'd0 : w_seg;
      end
    end
  end

  assign o_led_out     = r_led;
  assign o_digit_en    = r_en;
  assign o_frame_start = r_fs;

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - self-checking bench for seven_segment_scan
module tb_seven_segment_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        load;
  logic        lz;
  logic [6:0]  led;
  logic [3:0]  en;
  logic        fs;

  int n_vec = 0;
  int n_bad = 0;

  seven_segment_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .i_clk(clk), .i_reset(rst), .i_digits_in(din), .i_load(load),
    .i_lz_blank(lz), .o_led_out(led), .o_digit_en(en), .o_frame_start(fs)
  );

  always #5 clk = ~clk;

  // Behavioural model: t is the cycle number since reset release.
  logic [6:0]  seg_tab [0:15];
  int          t = 0;
  bit          run = 0;
  bit          m_valid = 0;
  logic [15:0] m_shadow = 0, m_active = 0;
  logic [6:0]  e_led = 0;
  logic [3:0]  e_en = 0;
  logic        e_fs = 0;

  initial begin
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
    seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1111011;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000000;
  end

  always @(posedge clk) begin
    if (rst) begin
      run = 0; t = 0; m_shadow = 0; m_active = 0;
      e_led = 0; e_en = 0; e_fs = 0;
    end else begin
      int cnt, idx, d;
      bit sup;
      if (run && (t % FR) == FR - 1) m_active = load ? din : m_shadow;
      if (load) m_shadow = din;
      if (run) t++; else begin run = 1; t = 0; end
      cnt  = t % SD;
      idx  = (t / SD) % 4;
      e_fs = ((t % FR) == 0);
      d    = (m_active >> (4 * idx)) & 15;
      sup  = lz && idx >= 1 && ((m_active >> (4 * idx)) == 0);
      if (cnt < BC) begin
        e_en = 0; e_led = 0;
      end else begin
        e_en  = 4'(1 << idx);
        e_led = sup ? 7'd0 : seg_tab[d];
      end
    end
    m_valid = 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", nm, t, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("led_model", {25'd0, led}, {25'd0, e_led});
      chk("en_model", {28'd0, en}, {28'd0, e_en});
      chk("fs_model", {31'd0, fs}, {31'd0, e_fs});
    end
  end

  task automatic wait_t(input int c);
    int n = 0;
    while (!(run && !rst && t == c)) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        n_vec++; n_bad++;
        $display("FAIL wait_t timeout got=%0d expected=%0d", t, c);
        return;
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    din = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [3:0] x_en, input logic [6:0] x_led);
    chk({nm, "_en"}, {28'd0, en}, {28'd0, x_en});
    chk({nm, "_led"}, {25'd0, led}, {25'd0, x_led});
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din = 16'd0; lz = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset", 4'd0, 7'd0);
    chk("reset_fs", {31'd0, fs}, 32'd0);
    rst = 1'b0;

    // Default frame and load alignment
    wait_t(0);  chk("fs_c0", {31'd0, fs}, 32'd1); lit("c0", 4'b0000, 7'd0);
    wait_t(2);  lit("c2", 4'b0001, 7'b1111110);
    wait_t(5);  pulse_load(16'h1234);
    wait_t(8);  lit("c8", 4'b0000, 7'd0);
    wait_t(10); lit("c10", 4'b0010, 7'b1111110);
    wait_t(32); chk("fs_c32", {31'd0, fs}, 32'd1);
    wait_t(34); lit("c34", 4'b0001, 7'b0110011);
    wait_t(42); lit("c42", 4'b0010, 7'b1111001);
    wait_t(50); lit("c50", 4'b0100, 7'b1101101);
    wait_t(58); lit("c58", 4'b1000, 7'b0110000);
    wait_t(64); chk("fs_c64", {31'd0, fs}, 32'd1);

    // Last load wins; boundary load shows without a frame of delay
    rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
    wait_t(10); pulse_load(16'h0005);
    wait_t(20); pulse_load(16'h0007);
    wait_t(34); lit("last_wins", 4'b0001, 7'b1110000);
    wait_t(63); pulse_load(16'h0009);
    wait_t(66); lit("boundary", 4'b0001, 7'b1111011);

    // Leading-zero suppression
    lz = 1'b1;
    wait_t(70);  pulse_load(16'h0070);
    wait_t(98);  lit("lz_d0", 4'b0001, 7'b1111110);
    wait_t(106); lit("lz_d1", 4'b0010, 7'b1110000);
    wait_t(114); lit("lz_d2", 4'b0100, 7'd0);
    wait_t(122); lit("lz_d3", 4'b1000, 7'd0);
    wait_t(130); pulse_load(16'h0000);
    wait_t(162); lit("lz0_d0", 4'b0001, 7'b1111110);
    wait_t(170); lit("lz0_d1", 4'b0010, 7'd0);

    // Invalid BCD
    lz = 1'b0;
    pulse_load(16'hFA00);
    wait_t(194); lit("inv_d0", 4'b0001, 7'b1111110);
    wait_t(202); lit("inv_d1", 4'b0010, 7'b1111110);
    wait_t(210); lit("inv_d2", 4'b0100, 7'd0);
    wait_t(218); lit("inv_d3", 4'b1000, 7'd0);

    // Reset mid-frame
    wait_t(230); pulse_load(16'h1234);
    wait_t(FR * 8 + 13); lit("pre_rst", 4'b0010, 7'b1111001);
    rst = 1'b1;
    @(negedge clk); lit("mid_rst", 4'd0, 7'd0);
    chk("mid_rst_fs", {31'd0, fs}, 32'd0);
    rst = 1'b0;
    wait_t(0); chk("rst_fs", {31'd0, fs}, 32'd1);
    wait_t(2); lit("rst_d0", 4'b0001, 7'b1111110);
    wait_t(42); lit("rst_d1", 4'b0010, 7'b1111110);

    // Randomized operation
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      @(negedge clk);
      for (int k = 0; k < 4; k++) v[4*k +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 12);
      din  = v;
      load = ($urandom % 8 == 0);
      if ($urandom % 64 == 0) lz = 1'($urandom);
      rst = ($urandom % 600 == 0);
    end
    @(negedge clk);
    load = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
